// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with row synchroniser, full-scan debounce
// and a registered status byte {pending, held, 2'b00, code} for the IO block.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  input  logic       rd_ack,
  output logic [7:0] keypad
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_CHK,
    S_HELD,
    S_RELEASE_CHK
  } state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 4; i++) s = s + 3'(v[i]);
    return s;
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) idx = 2'(i);
    return idx;
  endfunction

  logic [3:0]       r_rows_s1, r_rows_s2;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_col;
  logic [1:0]       r_acc_n;
  logic [3:0]       r_acc_code;
  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_cand;
  logic [3:0]       r_code;
  logic             r_held;
  logic             r_pend;

  logic             w_last;
  logic             w_scan_done;
  logic [3:0]       w_lows;
  logic [2:0]       w_pc;
  logic [2:0]       w_sum;
  logic [1:0]       w_acc_n;
  logic [3:0]       w_acc_code;
  logic             w_none;
  logic             w_single;
  state_t           w_state;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_inc;
  logic [3:0]       w_cand;
  logic             w_confirm;
  logic             w_release;

  assign w_last      = (r_div == DIV_LAST);
  assign w_scan_done = w_last && (r_col == 2'd3);
  assign w_lows      = ~r_rows_s2;
  assign w_pc        = popcount4(w_lows);
  assign w_sum       = {1'b0, r_acc_n} + w_pc;
  // Accumulator saturates at 2: beyond "more than one key" the exact count is irrelevant.
  assign w_acc_n     = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_acc_code  = (r_acc_n == 2'd0 && w_pc == 3'd1) ? {low_row(w_lows), r_col} : r_acc_code;
  assign w_none      = (w_acc_n == 2'd0);
  assign w_single    = (w_acc_n == 2'd1);
  assign w_count_inc = r_count + CNT_ONE;

  always_comb begin
    w_state   = r_state;
    w_count   = r_count;
    w_cand    = r_cand;
    w_confirm = 1'b0;
    w_release = 1'b0;
    if (w_scan_done) begin
      case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand = w_acc_code;
            if (DEBOUNCE_SCANS == 1) begin
              w_confirm = 1'b1;
              w_state   = S_HELD;
              w_count   = '0;
            end else begin
              w_count = CNT_ONE;
              w_state = S_PRESS_CHK;
            end
          end
        end
        S_PRESS_CHK: begin
          if (w_single && w_acc_code == r_cand) begin
            if (w_count_inc >= DB_MAX) begin
              w_confirm = 1'b1;
              w_state   = S_HELD;
              w_count   = '0;
            end else begin
              w_count = w_count_inc;
            end
          end else begin
            w_state = S_IDLE;
            w_count = '0;
          end
        end
        S_HELD: begin
          if (w_none) begin
            if (DEBOUNCE_SCANS == 1) begin
              w_release = 1'b1;
              w_state   = S_IDLE;
              w_count   = '0;
            end else begin
              w_count = CNT_ONE;
              w_state = S_RELEASE_CHK;
            end
          end
        end
        default: begin
          if (w_none) begin
            if (w_count_inc >= DB_MAX) begin
              w_release = 1'b1;
              w_state   = S_IDLE;
              w_count   = '0;
            end else begin
              w_count = w_count_inc;
            end
          end else begin
            w_state = S_HELD;
            w_count = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_s1  <= 4'hF;
      r_rows_s2  <= 4'hF;
      r_div      <= '0;
      r_col      <= 2'd0;
      r_acc_n    <= 2'd0;
      r_acc_code <= 4'd0;
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_cand     <= 4'd0;
      r_code     <= 4'd0;
      r_held     <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_rows_s1 <= rows_n;
      r_rows_s2 <= r_rows_s1;
      if (w_last) begin
        r_div <= '0;
        r_col <= r_col + 2'd1;
        // Column 3 closes the scan; the FSM consumes w_acc_* this cycle.
        if (r_col == 2'd3) begin
          r_acc_n    <= 2'd0;
          r_acc_code <= 4'd0;
        end else begin
          r_acc_n    <= w_acc_n;
          r_acc_code <= w_acc_code;
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      r_state <= w_state;
      r_count <= w_count;
      r_cand  <= w_cand;
      if (w_confirm) r_code <= w_cand;
      if (w_confirm)      r_held <= 1'b1;
      else if (w_release) r_held <= 1'b0;
      // A confirm in the same cycle as rd_ack must leave the flag set.
      r_pend <= w_confirm | (r_pend & ~rd_ack);
    end
  end

  assign cols_n = ~(4'b0001 << r_col);
  assign keypad = {r_pend, r_held, 2'b00, r_code};

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3): a modelled key
// matrix drives rows_n from cols_n; checks happen 1 ns after the rising edge.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic       rd_ack = 1'b0;
  logic [7:0] keypad;
  logic [15:0] pressed = 16'h0000;

  int n_assert = 0;
  int n_fail   = 0;
  int e        = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rows_n (rows_n),
    .cols_n (cols_n),
    .rd_ack (rd_ack),
    .keypad (keypad)
  );

  always #5 clk = ~clk;

  always_comb begin
    rows_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int t);
    while (e < t) step();
  endtask

  initial begin
    // Reset, column stepping
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_keypad", keypad, 8'h00);
    check("rst_cols", {4'h0, cols_n}, 8'h0E);
    rst_n = 1'b1;
    e = 0;
    run_to(3);  check("col0_hold", {4'h0, cols_n}, 8'h0E);
    run_to(4);  check("col1", {4'h0, cols_n}, 8'h0D);
    run_to(8);  check("col2", {4'h0, cols_n}, 8'h0B);
    run_to(12); check("col3", {4'h0, cols_n}, 8'h07);
    run_to(16); check("col_wrap", {4'h0, cols_n}, 8'h0E);

    // Bounce: key 5 for one scan, then none, five times
    for (int i = 0; i < 5; i++) begin
      pressed = 16'h0020;
      run_to(32 + 32*i);
      check("bounce_single", keypad, 8'h00);
      pressed = 16'h0000;
      run_to(48 + 32*i);
      check("bounce_none", keypad, 8'h00);
    end

    // Clean press of key 9 (row2, col1), then acknowledge
    pressed = 16'h0200;
    run_to(223); check("press_before", keypad, 8'h00);
    run_to(224); check("press_confirm", keypad, 8'hC9);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("ack_clear", keypad, 8'h49);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("ack_idle", keypad, 8'h49);

    // Release: two NONE scans, key again, three NONE scans
    run_to(240);
    pressed = 16'h0000;
    run_to(272);
    check("release_partial", keypad, 8'h49);
    pressed = 16'h0200;
    run_to(288);
    pressed = 16'h0000;
    run_to(320); check("release_2none", keypad, 8'h49);
    run_to(335); check("release_before", keypad, 8'h49);
    run_to(336); check("release_done", keypad, 8'h09);

    // Multi-key on column 2 (rows 0 and 3): never confirms
    pressed = 16'h4004;
    run_to(400); check("multi_nochange", keypad, 8'h09);

    // Confirm of key 15 colliding with rd_ack
    pressed = 16'h8000;
    run_to(447); check("coll_before", keypad, 8'h09);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("coll_set_wins", keypad, 8'hCF);

    // Release key 15 (flag still pending), then key 6 into PRESS_CHK and reset
    pressed = 16'h0000;
    run_to(496); check("pend_kept", keypad, 8'h8F);
    pressed = 16'h0040;
    run_to(514);
    rst_n = 1'b0;
    #1;
    check("async_rst_keypad", keypad, 8'h00);
    check("async_rst_cols", {4'h0, cols_n}, 8'h0E);
    repeat (2) step();
    rst_n = 1'b1;
    e = 0;
    run_to(47); check("rst_press_before", keypad, 8'h00);
    run_to(48); check("rst_press_confirm", keypad, 8'hC6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
